// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control unit: sequences IF/ID/EX1/EX2/MEM/WB/HALT and
// drives datapath controls combinationally from the state and live inputs.
module mc_control_fsm #(
    parameter int ALU_OP_W      = 2,
    parameter int CNT_W         = 32,
    parameter int HALT_ON_ECALL = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    input  logic                bcond,
    input  logic                halt_req,
    output logic [2:0]          state,
    output logic                mem_req,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                pc_write,
    output logic                pc_write_not_cond,
    output logic                pc_source,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                is_ecall,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [CNT_W-1:0]    retired,
    output logic                halted
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX1  = 3'd2;
    localparam logic [2:0] S_EX2  = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [1:0] SRC_B    = 2'b00;
    localparam logic [1:0] SRC_FOUR = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    logic [2:0] next_state;
    logic       halt_ecall;

    assign halt_ecall = (HALT_ON_ECALL != 0) && halt_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (instr_done) begin
            retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IF:  if (mem_ready) next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_JAL: next_state = S_WB;
                    OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
                        next_state = S_EX1;
                    OP_ECALL: next_state = halt_ecall ? S_HALT : S_IF;
                    default:  next_state = S_IF;
                endcase
            end
            S_EX1: begin
                case (opcode)
                    OP_ARITH, OP_ARITH_IMM, OP_JALR: next_state = S_WB;
                    OP_LOAD, OP_STORE:               next_state = S_MEM;
                    OP_BRANCH: next_state = bcond ? S_EX2 : S_IF;
                    default:   next_state = S_IF;
                endcase
            end
            S_EX2: next_state = S_IF;
            S_MEM: if (mem_ready) next_state = (opcode == OP_LOAD) ? S_WB : S_IF;
            S_WB:   next_state = S_IF;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

    always_comb begin
        mem_req           = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        i_or_d            = 1'b0;
        ir_write          = 1'b0;
        reg_write         = 1'b0;
        mem_to_reg        = 1'b0;
        pc_write          = 1'b0;
        pc_write_not_cond = 1'b0;
        pc_source         = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRC_B;
        alu_op            = ALU_ADD;
        is_ecall          = 1'b0;
        illegal_op        = 1'b0;
        instr_done        = 1'b0;
        halted            = 1'b0;
        case (state)
            S_IF: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_ID: begin
                alu_src_b = SRC_FOUR;
                case (opcode)
                    OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: begin
                    end
                    OP_ECALL: begin
                        is_ecall   = 1'b1;
                        instr_done = 1'b1;
                        pc_write   = !halt_ecall;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_EX1: begin
                case (opcode)
                    OP_ARITH: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALU_FUNCT;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_IMM;
                        alu_op    = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_IMM;
                    end
                    OP_JALR: alu_src_b = SRC_FOUR;
                    OP_BRANCH: begin
                        alu_src_a         = 1'b1;
                        alu_op            = ALU_FUNCT;
                        pc_write_not_cond = 1'b1;
                        pc_source         = 1'b1;
                        instr_done        = !bcond;
                    end
                    default: begin
                    end
                endcase
            end
            S_EX2: begin
                alu_src_b  = SRC_IMM;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                // A store retires in its completion cycle by bumping PC here.
                if (opcode == OP_STORE && mem_ready) begin
                    alu_src_b  = SRC_FOUR;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        alu_src_b  = SRC_FOUR;
                        mem_to_reg = 1'b1;
                    end
                    OP_JAL:  alu_src_b = SRC_IMM;
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_IMM;
                    end
                    default: alu_src_b = SRC_FOUR;
                endcase
            end
            S_HALT:  halted = 1'b1;
            default: begin
            end
        endcase
        // Architectural writes must never fire while reset is held.
        if (reset) begin
            pc_write          = 1'b0;
            pc_write_not_cond = 1'b0;
            ir_write          = 1'b0;
            reg_write         = 1'b0;
            mem_write         = 1'b0;
            instr_done        = 1'b0;
            illegal_op        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus a randomized instruction
// stream checked against a per-instruction phase model.
module tb_mc_control_fsm;

    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [19:0] C_MREQ  = 20'h80000;
    localparam logic [19:0] C_MRD   = 20'h40000;
    localparam logic [19:0] C_MWR   = 20'h20000;
    localparam logic [19:0] C_IORD  = 20'h10000;
    localparam logic [19:0] C_IRW   = 20'h08000;
    localparam logic [19:0] C_RW    = 20'h04000;
    localparam logic [19:0] C_M2R   = 20'h02000;
    localparam logic [19:0] C_PCW   = 20'h01000;
    localparam logic [19:0] C_PCWNC = 20'h00800;
    localparam logic [19:0] C_PCSRC = 20'h00400;
    localparam logic [19:0] C_SRCA  = 20'h00200;
    localparam logic [19:0] C_IMM   = 20'h00100;
    localparam logic [19:0] C_FOUR  = 20'h00080;
    localparam logic [19:0] C_FUNCT = 20'h00040;
    localparam logic [19:0] C_ECALL = 20'h00010;
    localparam logic [19:0] C_ILL   = 20'h00008;
    localparam logic [19:0] C_DONE  = 20'h00004;
    localparam logic [19:0] C_HALT  = 20'h00002;

    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic [19:0] c;
    } step_t;

    logic clk = 1'b0;
    logic reset, mem_ready, bcond, halt_req;
    logic [6:0] opcode;

    logic [2:0]  state, state4;
    logic        mem_req, mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg;
    logic        pc_write, pc_write_not_cond, pc_source, alu_src_a, is_ecall, illegal_op;
    logic        instr_done, halted;
    logic [1:0]  alu_src_b, alu_op;
    logic [31:0] retired;
    logic        mem_req4, mem_read4, mem_write4, i_or_d4, ir_write4, reg_write4, mem_to_reg4;
    logic        pc_write4, pc_write_not_cond4, pc_source4, alu_src_a4, is_ecall4, illegal_op4;
    logic        instr_done4, halted4;
    logic [1:0]  alu_src_b4, alu_op4;
    logic [3:0]  retired4;

    logic [19:0] act;
    step_t       path[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_ret = 0;

    assign act = {mem_req, mem_read, mem_write, i_or_d, ir_write, reg_write, mem_to_reg,
                  pc_write, pc_write_not_cond, pc_source, alu_src_a, alu_src_b, alu_op,
                  is_ecall, illegal_op, instr_done, halted, 1'b0};

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond),
        .halt_req(halt_req), .state(state), .mem_req(mem_req), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_write_not_cond(pc_write_not_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .is_ecall(is_ecall), .illegal_op(illegal_op), .instr_done(instr_done),
        .retired(retired), .halted(halted)
    );

    mc_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond),
        .halt_req(halt_req), .state(state4), .mem_req(mem_req4), .mem_read(mem_read4),
        .mem_write(mem_write4), .i_or_d(i_or_d4), .ir_write(ir_write4), .reg_write(reg_write4),
        .mem_to_reg(mem_to_reg4), .pc_write(pc_write4), .pc_write_not_cond(pc_write_not_cond4),
        .pc_source(pc_source4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .is_ecall(is_ecall4), .illegal_op(illegal_op4), .instr_done(instr_done4),
        .retired(retired4), .halted(halted4)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Phase sequence one instruction walks through, with the controls each phase asserts.
    task automatic build_path(input logic [6:0] op, input int iw, input int mw, input logic bc);
        logic [19:0] mb;
        path.delete();
        repeat (iw) path.push_back({3'd0, 1'b0, C_MREQ | C_MRD});
        path.push_back({3'd0, 1'b1, C_MREQ | C_MRD | C_IRW});
        case (op)
            OP_ARITH, OP_IMM: begin
                path.push_back({3'd1, 1'b0, C_FOUR});
                path.push_back({3'd2, 1'b0, C_SRCA | C_FUNCT | ((op == OP_IMM) ? C_IMM : 20'h0)});
                path.push_back({3'd5, 1'b0, C_RW | C_PCW | C_FOUR | C_DONE});
            end
            OP_LOAD, OP_STORE: begin
                mb = C_MREQ | C_IORD | ((op == OP_LOAD) ? C_MRD : C_MWR);
                path.push_back({3'd1, 1'b0, C_FOUR});
                path.push_back({3'd2, 1'b0, C_SRCA | C_IMM});
                repeat (mw) path.push_back({3'd4, 1'b0, mb});
                path.push_back({3'd4, 1'b1, mb | ((op == OP_STORE) ? (C_PCW | C_FOUR | C_DONE) : 20'h0)});
                if (op == OP_LOAD) path.push_back({3'd5, 1'b0, C_RW | C_PCW | C_M2R | C_FOUR | C_DONE});
            end
            OP_BRANCH: begin
                path.push_back({3'd1, 1'b0, C_FOUR});
                path.push_back({3'd2, 1'b0, C_SRCA | C_FUNCT | C_PCWNC | C_PCSRC | (bc ? 20'h0 : C_DONE)});
                if (bc) path.push_back({3'd3, 1'b0, C_IMM | C_PCW | C_DONE});
            end
            OP_JAL: begin
                path.push_back({3'd1, 1'b0, C_FOUR});
                path.push_back({3'd5, 1'b0, C_RW | C_PCW | C_IMM | C_DONE});
            end
            OP_JALR: begin
                path.push_back({3'd1, 1'b0, C_FOUR});
                path.push_back({3'd2, 1'b0, C_FOUR});
                path.push_back({3'd5, 1'b0, C_RW | C_PCW | C_SRCA | C_IMM | C_DONE});
            end
            OP_ECALL: path.push_back({3'd1, 1'b0, C_FOUR | C_ECALL | C_DONE | C_PCW});
            default:  path.push_back({3'd1, 1'b0, C_FOUR | C_PCW | C_ILL | C_DONE});
        endcase
    endtask

    task automatic test_reset;
        reset = 1'b1; opcode = OP_ARITH; mem_ready = 1'b1; bcond = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
        n_tests++; if (retired4 !== 4'd0) begin n_fail++; $display("FAIL reset_retired4: got %0d want 0", retired4); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
        n_tests++; if ({ir_write, instr_done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_forced_ir_write: got %b want 00", {ir_write, instr_done}); end
        tick;
        reset = 1'b0; mem_ready = 1'b0; exp_ret = 0;
        @(negedge clk);
        n_tests++; if ({mem_req, mem_read, i_or_d, ir_write} !== 4'b1100) begin
            n_fail++; $display("FAIL if_wait_ctrl: got %b want 1100", {mem_req, mem_read, i_or_d, ir_write}); end
        tick;
    endtask

    task automatic test_add;
        int exp_st[4] = '{0, 1, 2, 5};
        opcode = OP_ARITH; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if (state !== 3'(exp_st[i])) begin
                n_fail++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i == 3) begin
                n_tests++; if ({reg_write, alu_src_b} !== 3'b101) begin
                    n_fail++; $display("FAIL add_wb_ctrl: got %b want 101", {reg_write, alu_src_b}); end
            end
            tick;
        end
        exp_ret++; mem_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL add_back_if: got %0d want 0", state); end
        n_tests++; if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL add_retired: got %0d want %0d", retired, exp_ret); end
        tick;
    endtask

    task automatic test_load_wait;
        logic rdy[8]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   exp_st[8] = '{0, 1, 2, 4, 4, 4, 4, 5};
        opcode = OP_LOAD;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            n_tests++; if (state !== 3'(exp_st[i])) begin
                n_fail++; $display("FAIL load_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (exp_st[i] == 4) begin
                n_tests++; if ({mem_read, i_or_d, mem_write} !== 3'b110) begin
                    n_fail++; $display("FAIL load_mem_ctrl[%0d]: got %b want 110", i, {mem_read, i_or_d, mem_write}); end
            end
            if (i == 7) begin
                n_tests++; if (mem_to_reg !== 1'b1) begin n_fail++; $display("FAIL load_mem_to_reg: got %b want 1", mem_to_reg); end
            end
            tick;
        end
        exp_ret++; mem_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL load_back_if: got %0d want 0", state); end
        n_tests++; if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL load_retired: got %0d want %0d", retired, exp_ret); end
        tick;
    endtask

    task automatic test_branch;
        for (int b = 0; b < 2; b++) begin
            opcode = OP_BRANCH; bcond = b[0]; mem_ready = 1'b1;
            for (int i = 0; i < 3 + b; i++) begin
                @(negedge clk);
                n_tests++; if (state !== 3'(i)) begin
                    n_fail++; $display("FAIL branch%0d_state[%0d]: got %0d want %0d", b, i, state, i); end
                if (i == 2) begin
                    n_tests++; if ({pc_write_not_cond, pc_source, instr_done} !== {2'b11, ~b[0]}) begin
                        n_fail++; $display("FAIL branch%0d_ex1: got %b want %b", b, {pc_write_not_cond, pc_source, instr_done}, {2'b11, ~b[0]}); end
                end
                if (i == 3) begin
                    n_tests++; if ({pc_write, alu_src_b, instr_done} !== 4'b1101) begin
                        n_fail++; $display("FAIL branch_ex2: got %b want 1101", {pc_write, alu_src_b, instr_done}); end
                end
                tick;
            end
            exp_ret++; mem_ready = 1'b0;
            @(negedge clk);
            n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL branch%0d_back_if: got %0d want 0", b, state); end
            n_tests++; if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL branch%0d_retired: got %0d want %0d", b, retired, exp_ret); end
            tick;
        end
    endtask

    task automatic test_illegal;
        opcode = 7'b0000000; mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        @(negedge clk);
        n_tests++; if ({state, illegal_op, pc_write, instr_done, alu_src_b} !== {3'd1, 3'b111, 2'b01}) begin
            n_fail++; $display("FAIL illegal_id: got %b want 00111101", {state, illegal_op, pc_write, instr_done, alu_src_b}); end
        tick;
        exp_ret++;
        @(negedge clk);
        n_tests++; if ({state, illegal_op} !== 4'b0000) begin
            n_fail++; $display("FAIL illegal_pulse_end: got %b want 0000", {state, illegal_op}); end
        n_tests++; if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL illegal_retired: got %0d want %0d", retired, exp_ret); end
        tick;
    endtask

    task automatic test_random;
        logic [6:0] ops[9] = '{OP_ARITH, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL, 7'h00};
        logic [6:0] bad[4] = '{7'h00, 7'h7f, 7'h37, 7'h17};
        logic [6:0] op;
        logic       bc;
        step_t      s;
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 7'h00) op = bad[$urandom_range(0, 3)];
            bc = 1'($urandom_range(0, 1));
            build_path(op, $urandom_range(0, 2), $urandom_range(0, 2), bc);
            for (int i = 0; i < path.size(); i++) begin
                s = path[i];
                opcode    = op;
                mem_ready = (s.st == 3'd0 || s.st == 3'd4) ? s.rdy : 1'($urandom);
                bcond     = (s.st == 3'd2 && op == OP_BRANCH) ? bc : 1'($urandom);
                halt_req  = (s.st == 3'd1 && op == OP_ECALL) ? 1'b0 : 1'($urandom);
                @(negedge clk);
                n_tests++; if (state !== s.st) begin
                    n_fail++; $display("FAIL rand_state[%0d.%0d] op=%b: got %0d want %0d", k, i, op, state, s.st); end
                n_tests++; if (act !== s.c) begin
                    n_fail++; $display("FAIL rand_ctrl[%0d.%0d] op=%b st=%0d: got %h want %h", k, i, op, s.st, act, s.c); end
                tick;
            end
            exp_ret++;
            n_tests++; if (retired !== 32'(exp_ret)) begin
                n_fail++; $display("FAIL rand_retired[%0d]: got %0d want %0d", k, retired, exp_ret); end
            n_tests++; if (retired4 !== 4'(exp_ret)) begin
                n_fail++; $display("FAIL rand_retired4[%0d]: got %0d want %0d", k, retired4, 4'(exp_ret)); end
        end
        mem_ready = 1'b0; halt_req = 1'b0; bcond = 1'b0;
        tick;
    endtask

    task automatic test_wrap;
        int  cyc;
        bit  done;
        reset = 1'b1; mem_ready = 1'b0;
        tick; tick;
        reset = 1'b0; exp_ret = 0;
        for (int n = 0; n < 16; n++) begin
            opcode = OP_ARITH; mem_ready = 1'b1; cyc = 0; done = 0;
            while (!done && cyc < 10) begin
                @(negedge clk);
                if (instr_done) done = 1;
                cyc++;
                tick;
            end
            n_tests++; if (!done) begin n_fail++; $display("FAIL wrap_timeout[%0d]: got no instr_done want one", n); end
            exp_ret++;
            n_tests++; if (retired4 !== 4'(exp_ret)) begin
                n_fail++; $display("FAIL wrap_retired4[%0d]: got %0d want %0d", n, retired4, 4'(exp_ret)); end
        end
        mem_ready = 1'b0;
        n_tests++; if (retired !== 32'd16) begin n_fail++; $display("FAIL wrap_retired32: got %0d want 16", retired); end
        tick;
    endtask

    task automatic test_store_reset;
        opcode = OP_STORE; mem_ready = 1'b1;
        tick; tick;
        mem_ready = 1'b0;
        tick;
        @(negedge clk);
        n_tests++; if ({state, mem_write} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL store_mem_wait: got %b want 1001", {state, mem_write}); end
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        n_tests++; if ({state, mem_write, pc_write, instr_done} !== {3'd4, 3'b000}) begin
            n_fail++; $display("FAIL store_reset_forced: got %b want 100000", {state, mem_write, pc_write, instr_done}); end
        tick;
        reset = 1'b0; mem_ready = 1'b0; exp_ret = 0;
        @(negedge clk);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL store_reset_state: got %0d want 0", state); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL store_reset_retired: got %0d want 0", retired); end
        tick;
    endtask

    task automatic test_ecall_halt;
        opcode = OP_ECALL; halt_req = 1'b1; mem_ready = 1'b1;
        tick;
        @(negedge clk);
        n_tests++; if ({state, is_ecall, instr_done, pc_write} !== {3'd1, 3'b110}) begin
            n_fail++; $display("FAIL ecall_id: got %b want 001110", {state, is_ecall, instr_done, pc_write}); end
        tick;
        exp_ret++;
        for (int i = 0; i < 10; i++) begin
            opcode = 7'($urandom); mem_ready = 1'($urandom); halt_req = 1'($urandom); bcond = 1'($urandom);
            @(negedge clk);
            n_tests++; if ({state, act} !== {3'd6, C_HALT}) begin
                n_fail++; $display("FAIL halt_hold[%0d]: got st=%0d ctrl=%h want st=6 ctrl=%h", i, state, act, C_HALT); end
            tick;
        end
        n_tests++; if (retired !== 32'(exp_ret)) begin n_fail++; $display("FAIL halt_retired: got %0d want %0d", retired, exp_ret); end
        reset = 1'b1;
        tick;
        reset = 1'b0; mem_ready = 1'b0; exp_ret = 0;
        @(negedge clk);
        n_tests++; if ({state, halted} !== 4'b0000) begin n_fail++; $display("FAIL halt_reset: got %b want 0000", {state, halted}); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL halt_reset_retired: got %0d want 0", retired); end
        tick;
    endtask

    initial begin
        reset = 1'b1; opcode = OP_ARITH; mem_ready = 1'b0; bcond = 1'b0; halt_req = 1'b0;
        tick;
        test_reset;
        test_add;
        test_load_wait;
        test_branch;
        test_illegal;
        test_random;
        test_wrap;
        test_store_reset;
        test_ecall_halt;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
